io_port_multi: RTL and testbench

// - Parametrised successor to the single-port GPIO/timer I/O block; the slave on the core's io_* bus.
// - Provides NUM_PORTS GPIO banks with per-bit direction control and synchronised inputs.
// - Provides rising-edge GPIO interrupts with write-1-to-clear status.
// - Provides a prescaled 64-bit mtime/mtimecmp timer; drives irq_mtimecmp and irq_gpio to the core.

---
 rtl/io_port_multi.sv | 193 +++++++++++++++++++
 tb/tb_io_port_multi.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_port_multi.sv
// io_port_multi: NUM_PORTS GPIO banks with rising-edge interrupts and a prescaled 64-bit mtime/mtimecmp timer.
// Writes commit in the access cycle and reads are registered (one cycle); no backpressure, every access completes.
module io_port_multi #(
    parameter int NUM_PORTS   = 2,
    parameter int GPIO_WIDTH  = 8,
    parameter int PRESC_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [7:0]                      io_addr,
    input  logic                            io_en,
    input  logic                            io_we,
    input  logic [31:0]                     io_data_write,
    output logic [31:0]                     io_data_read,
    input  logic [NUM_PORTS*GPIO_WIDTH-1:0] gpio_in,
    output logic [NUM_PORTS*GPIO_WIDTH-1:0] gpio_out,
    output logic [NUM_PORTS*GPIO_WIDTH-1:0] gpio_oe,
    output logic                            irq_mtimecmp,
    output logic                            irq_gpio
);
    localparam int PW        = NUM_PORTS * GPIO_WIDTH;
    localparam int IRQ_BANKS = (GPIO_WIDTH <= 8) ? NUM_PORTS : 1;
    localparam int IRQ_BITS  = IRQ_BANKS * GPIO_WIDTH;
    localparam int SLOT      = (GPIO_WIDTH <= 8) ? 8 : 32;

    localparam logic [5:0] A_OUT    = 6'h00;
    localparam logic [5:0] A_DIR    = 6'h04;
    localparam logic [5:0] A_IN     = 6'h08;
    localparam logic [5:0] A_MT_LO  = 6'h0C;
    localparam logic [5:0] A_MT_HI  = 6'h0D;
    localparam logic [5:0] A_CMP_LO = 6'h0E;
    localparam logic [5:0] A_CMP_HI = 6'h0F;
    localparam logic [5:0] A_PRESC  = 6'h10;
    localparam logic [5:0] A_STATUS = 6'h11;
    localparam logic [5:0] A_IRQ_EN = 6'h12;

    localparam logic [PRESC_WIDTH-1:0] PRESC_ONE = 1;

    logic [PW-1:0]          out_q, out_d;
    logic [PW-1:0]          dir_q, dir_d;
    logic [PW-1:0]          sync1_q, sync1_d;
    logic [PW-1:0]          sync2_q, sync2_d;
    logic [IRQ_BITS-1:0]    prev_q, prev_d;
    logic [IRQ_BITS-1:0]    status_q, status_d;
    logic [IRQ_BITS-1:0]    irq_en_q, irq_en_d;
    logic [63:0]            mtime_q, mtime_d;
    logic [63:0]            mtimecmp_q, mtimecmp_d;
    logic [PRESC_WIDTH-1:0] presc_cnt_q, presc_cnt_d;
    logic [PRESC_WIDTH-1:0] prescale_q, prescale_d;
    logic [31:0]            shadow_q, shadow_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   irq_cmp_q, irq_cmp_d;

    logic [5:0]             widx;
    logic                   wr_en;
    logic                   rd_en;
    logic                   tick;
    logic [IRQ_BITS-1:0]    edge_set;
    logic [IRQ_BITS-1:0]    w1c;
    logic [31:0]            rd_word;
    logic                   unused_addr_bits;

    assign widx             = io_addr[7:2];
    assign wr_en            = io_en & io_we;
    assign rd_en            = io_en & ~io_we;
    assign unused_addr_bits = ^io_addr[1:0];

    // Read mux; anything unmapped or beyond NUM_PORTS falls through to zero.
    always_comb begin
        rd_word = '0;
        for (int n = 0; n < NUM_PORTS; n++) begin
            if (widx == A_OUT + 6'(n)) rd_word[GPIO_WIDTH-1:0] = out_q[n*GPIO_WIDTH +: GPIO_WIDTH];
            if (widx == A_DIR + 6'(n)) rd_word[GPIO_WIDTH-1:0] = dir_q[n*GPIO_WIDTH +: GPIO_WIDTH];
            if (widx == A_IN + 6'(n))  rd_word[GPIO_WIDTH-1:0] = sync2_q[n*GPIO_WIDTH +: GPIO_WIDTH];
        end
        case (widx)
            A_MT_LO:  rd_word = mtime_q[31:0];
            A_MT_HI:  rd_word = shadow_q;
            A_CMP_LO: rd_word = mtimecmp_q[31:0];
            A_CMP_HI: rd_word = mtimecmp_q[63:32];
            A_PRESC:  rd_word[PRESC_WIDTH-1:0] = prescale_q;
            A_STATUS: begin
                for (int b = 0; b < IRQ_BANKS; b++)
                    rd_word[b*SLOT +: GPIO_WIDTH] = status_q[b*GPIO_WIDTH +: GPIO_WIDTH];
            end
            A_IRQ_EN: begin
                for (int b = 0; b < IRQ_BANKS; b++)
                    rd_word[b*SLOT +: GPIO_WIDTH] = irq_en_q[b*GPIO_WIDTH +: GPIO_WIDTH];
            end
            default: ;
        endcase
    end

    always_comb begin
        out_d      = out_q;
        dir_d      = dir_q;
        irq_en_d   = irq_en_q;
        mtimecmp_d = mtimecmp_q;
        prescale_d = prescale_q;
        shadow_d   = shadow_q;
        rdata_d    = rdata_q;
        w1c        = '0;

        sync1_d  = gpio_in;
        sync2_d  = sync1_q;
        prev_d   = sync2_q[IRQ_BITS-1:0];
        edge_set = sync2_q[IRQ_BITS-1:0] & ~prev_q;

        // >= rather than == so lowering PRESCALE below the live count cannot stall the timer
        tick        = (presc_cnt_q >= prescale_q);
        presc_cnt_d = tick ? '0 : presc_cnt_q + PRESC_ONE;
        mtime_d     = tick ? mtime_q + 64'd1 : mtime_q;
        irq_cmp_d   = (mtime_q >= mtimecmp_q);

        if (wr_en) begin
            for (int n = 0; n < NUM_PORTS; n++) begin
                if (widx == A_OUT + 6'(n)) out_d[n*GPIO_WIDTH +: GPIO_WIDTH] = io_data_write[GPIO_WIDTH-1:0];
                if (widx == A_DIR + 6'(n)) dir_d[n*GPIO_WIDTH +: GPIO_WIDTH] = io_data_write[GPIO_WIDTH-1:0];
            end
            case (widx)
                A_MT_LO: begin
                    mtime_d     = {mtime_q[63:32], io_data_write};
                    presc_cnt_d = '0;
                end
                A_MT_HI: begin
                    mtime_d     = {io_data_write, mtime_q[31:0]};
                    presc_cnt_d = '0;
                end
                A_CMP_LO: mtimecmp_d[31:0]  = io_data_write;
                A_CMP_HI: mtimecmp_d[63:32] = io_data_write;
                A_PRESC:  prescale_d        = io_data_write[PRESC_WIDTH-1:0];
                A_STATUS: begin
                    for (int b = 0; b < IRQ_BANKS; b++)
                        w1c[b*GPIO_WIDTH +: GPIO_WIDTH] = io_data_write[b*SLOT +: GPIO_WIDTH];
                end
                A_IRQ_EN: begin
                    for (int b = 0; b < IRQ_BANKS; b++)
                        irq_en_d[b*GPIO_WIDTH +: GPIO_WIDTH] = io_data_write[b*SLOT +: GPIO_WIDTH];
                end
                default: ;
            endcase
        end

        if (rd_en) begin
            rdata_d = rd_word;
            if (widx == A_MT_LO) shadow_d = mtime_q[63:32];
        end

        // A new edge in the same cycle as a clear keeps the bit set
        status_d = (status_q & ~w1c) | edge_set;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q       <= '0;
            dir_q       <= '0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            prev_q      <= '0;
            status_q    <= '0;
            irq_en_q    <= '0;
            mtime_q     <= '0;
            mtimecmp_q  <= '1;
            presc_cnt_q <= '0;
            prescale_q  <= '0;
            shadow_q    <= '0;
            rdata_q     <= '0;
            irq_cmp_q   <= 1'b0;
        end else begin
            out_q       <= out_d;
            dir_q       <= dir_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            status_q    <= status_d;
            irq_en_q    <= irq_en_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            presc_cnt_q <= presc_cnt_d;
            prescale_q  <= prescale_d;
            shadow_q    <= shadow_d;
            rdata_q     <= rdata_d;
            irq_cmp_q   <= irq_cmp_d;
        end
    end

    assign io_data_read = rdata_q;
    assign gpio_out     = out_q;
    assign gpio_oe      = dir_q;
    assign irq_mtimecmp = irq_cmp_q;
    assign irq_gpio     = |(status_q & irq_en_q);

endmodule

// File: tb/tb_io_port_multi.sv
// Bench for io_port_multi (2 banks x 8 bits): directed literal checks plus randomized traffic
// compared every cycle against a register-level behavioural model.
module tb_io_port_multi;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  io_addr;
    logic        io_en;
    logic        io_we;
    logic [31:0] io_data_write;
    logic [31:0] io_data_read;
    logic [15:0] gpio_in;
    logic [15:0] gpio_out;
    logic [15:0] gpio_oe;
    logic        irq_mtimecmp;
    logic        irq_gpio;

    int n_checks = 0;
    int n_fail   = 0;

    io_port_multi #(.NUM_PORTS(2), .GPIO_WIDTH(8), .PRESC_WIDTH(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .io_addr       (io_addr),
        .io_en         (io_en),
        .io_we         (io_we),
        .io_data_write (io_data_write),
        .io_data_read  (io_data_read),
        .gpio_in       (gpio_in),
        .gpio_out      (gpio_out),
        .gpio_oe       (gpio_oe),
        .irq_mtimecmp  (irq_mtimecmp),
        .irq_gpio      (irq_gpio)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: register file of the block as seen by software.
    logic [15:0] m_out, m_dir, m_s1, m_s2, m_prev, m_status, m_irqen;
    logic [63:0] m_mtime, m_cmp;
    logic [31:0] m_cnt, m_presc, m_shadow, m_rdata;
    logic        m_irqcmp;

    task automatic m_reset();
        m_out = 0; m_dir = 0; m_s1 = 0; m_s2 = 0; m_prev = 0; m_status = 0; m_irqen = 0;
        m_mtime = 0; m_cmp = '1; m_cnt = 0; m_presc = 0; m_shadow = 0; m_rdata = 0; m_irqcmp = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [7:0] a);
        case ({a[7:2], 2'b00})
            8'h00: return {24'd0, m_out[7:0]};
            8'h04: return {24'd0, m_out[15:8]};
            8'h10: return {24'd0, m_dir[7:0]};
            8'h14: return {24'd0, m_dir[15:8]};
            8'h20: return {24'd0, m_s2[7:0]};
            8'h24: return {24'd0, m_s2[15:8]};
            8'h30: return m_mtime[31:0];
            8'h34: return m_shadow;
            8'h38: return m_cmp[31:0];
            8'h3C: return m_cmp[63:32];
            8'h40: return m_presc;
            8'h44: return {16'd0, m_status};
            8'h48: return {16'd0, m_irqen};
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_step(input logic en, input logic we, input logic [7:0] a,
                          input logic [31:0] wd, input logic [15:0] gin);
        logic [7:0]  wa;
        logic [63:0] old_mt;
        logic [15:0] edges;
        logic [15:0] clr;
        logic        new_irq;
        wa      = {a[7:2], 2'b00};
        old_mt  = m_mtime;
        edges   = m_s2 & ~m_prev;
        clr     = 0;
        new_irq = (m_mtime >= m_cmp);
        if (en && !we) begin
            m_rdata = m_read(a);
            if (wa == 8'h30) m_shadow = m_mtime[63:32];
        end
        if (m_cnt >= m_presc) begin
            m_cnt   = 0;
            m_mtime = m_mtime + 1;
        end else begin
            m_cnt = m_cnt + 1;
        end
        if (en && we) begin
            case (wa)
                8'h00: m_out[7:0]   = wd[7:0];
                8'h04: m_out[15:8]  = wd[7:0];
                8'h10: m_dir[7:0]   = wd[7:0];
                8'h14: m_dir[15:8]  = wd[7:0];
                8'h30: begin m_mtime = {old_mt[63:32], wd}; m_cnt = 0; end
                8'h34: begin m_mtime = {wd, old_mt[31:0]}; m_cnt = 0; end
                8'h38: m_cmp[31:0]  = wd;
                8'h3C: m_cmp[63:32] = wd;
                8'h40: m_presc      = {16'd0, wd[15:0]};
                8'h44: clr          = wd[15:0];
                8'h48: m_irqen      = wd[15:0];
                default: ;
            endcase
        end
        m_status = (m_status & ~clr) | edges;
        m_prev   = m_s2;
        m_s2     = m_s1;
        m_s1     = gin;
        m_irqcmp = new_irq;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) m_reset();
        else       m_step(io_en, io_we, io_addr, io_data_write, gpio_in);
    end

    // Continuous comparison of every output against the model.
    always @(negedge clk) begin
        check("io_data_read", {32'd0, io_data_read}, {32'd0, m_rdata});
        check("gpio_out", {48'd0, gpio_out}, {48'd0, m_out});
        check("gpio_oe", {48'd0, gpio_oe}, {48'd0, m_dir});
        check("irq_mtimecmp", {63'd0, irq_mtimecmp}, {63'd0, m_irqcmp});
        check("irq_gpio", {63'd0, irq_gpio}, {63'd0, |(m_status & m_irqen)});
    end

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        io_en = 1; io_we = 1; io_addr = a; io_data_write = d;
        @(negedge clk);
        io_en = 0; io_we = 0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        io_en = 1; io_we = 0; io_addr = a;
        @(negedge clk);
        io_en = 0;
        d = io_data_read;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

    logic [7:0] addr_tbl [19] = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h20, 8'h24, 8'h28,
                                  8'h30, 8'h34, 8'h38, 8'h3C, 8'h40, 8'h44, 8'h48, 8'h4C, 8'h80, 8'hFC};

    initial begin
        logic [31:0] d;
        logic [7:0]  a;
        m_reset();
        io_en = 0; io_we = 0; io_addr = 0; io_data_write = 0; gpio_in = 0;
        #1 reset = 1;
        repeat (3) @(negedge clk);
        reset = 0;

        check("reset_rdata", {32'd0, io_data_read}, 64'd0);
        check("reset_gpio_out", {48'd0, gpio_out}, 64'd0);
        check("reset_gpio_oe", {48'd0, gpio_oe}, 64'd0);
        check("reset_irq_mtimecmp", {63'd0, irq_mtimecmp}, 64'd0);
        check("reset_irq_gpio", {63'd0, irq_gpio}, 64'd0);

        wr(8'h10, 32'hFF);
        wr(8'h00, 32'hA5);
        check("dir0_oe", {56'd0, gpio_oe[7:0]}, 64'hFF);
        check("out0_out", {56'd0, gpio_out[7:0]}, 64'hA5);

        gpio_in[15:8] = 8'h3C;
        idle(2);
        rd(8'h24, d);
        check("in1_sync", {32'd0, d}, 64'h3C);
        rd(8'h28, d);
        check("unmapped_bank2_in", {32'd0, d}, 64'd0);
        rd(8'h4C, d);
        check("unmapped_4c", {32'd0, d}, 64'd0);

        wr(8'h44, 32'hFFFF);
        wr(8'h48, 32'h01);
        gpio_in[0] = 1'b1;
        idle(3);
        rd(8'h44, d);
        check("status_edge", {32'd0, d}, 64'h01);
        check("irq_gpio_set", {63'd0, irq_gpio}, 64'd1);
        wr(8'h44, 32'h01);
        rd(8'h44, d);
        check("status_w1c", {32'd0, d}, 64'd0);
        check("irq_gpio_clr", {63'd0, irq_gpio}, 64'd0);
        gpio_in[0] = 1'b0;
        idle(3);
        gpio_in[0] = 1'b1;
        idle(2);
        wr(8'h44, 32'h01);
        rd(8'h44, d);
        check("status_set_wins", {32'd0, d}, 64'h01);

        wr(8'h40, 32'd3);
        wr(8'h38, 32'd10);
        wr(8'h3C, 32'd0);
        wr(8'h34, 32'd0);
        wr(8'h30, 32'd0);
        idle(40);
        check("timer_irq_before", {63'd0, irq_mtimecmp}, 64'd0);
        idle(1);
        check("timer_irq_rise", {63'd0, irq_mtimecmp}, 64'd1);
        wr(8'h3C, 32'd1);
        check("cmp_hi_irq_lag", {63'd0, irq_mtimecmp}, 64'd1);
        idle(1);
        check("cmp_hi_irq_drop", {63'd0, irq_mtimecmp}, 64'd0);

        wr(8'h34, 32'd0);
        wr(8'h30, 32'hFFFF_FFFF);
        idle(4);
        rd(8'h30, d);
        check("carry_lo", {32'd0, d}, 64'd0);
        rd(8'h34, d);
        check("carry_hi", {32'd0, d}, 64'd1);

        wr(8'h40, 32'd0);
        wr(8'h34, 32'd5);
        wr(8'h30, 32'hFFFF_FFFE);
        rd(8'h30, d);
        check("atomic_lo", {32'd0, d}, 64'hFFFF_FFFE);
        idle(1);
        rd(8'h34, d);
        check("atomic_hi_shadow", {32'd0, d}, 64'd5);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) gpio_in = gpio_in ^ 16'(32'd1 << $urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) begin
                a = addr_tbl[$urandom_range(0, 18)] | 8'($urandom_range(0, 3));
                io_en = 1; io_we = 1'($urandom_range(0, 1)); io_addr = a; io_data_write = $urandom;
                if (a[7:2] == 6'h10) io_data_write = $urandom_range(0, 4);
            end else begin
                io_en = 0; io_we = 1'($urandom_range(0, 1)); io_addr = 8'($urandom); io_data_write = $urandom;
            end
            @(negedge clk);
        end
        io_en = 0; io_we = 0;

        wr(8'h10, 32'hFF);
        wr(8'h00, 32'h33);
        io_en = 1; io_we = 1; io_addr = 8'h00; io_data_write = 32'h5A;
        #2 reset = 1;
        #1;
        check("rst_async_out", {48'd0, gpio_out}, 64'd0);
        check("rst_async_oe", {48'd0, gpio_oe}, 64'd0);
        check("rst_async_rdata", {32'd0, io_data_read}, 64'd0);
        check("rst_async_irq_cmp", {63'd0, irq_mtimecmp}, 64'd0);
        check("rst_async_irq_gpio", {63'd0, irq_gpio}, 64'd0);
        @(negedge clk);
        io_en = 0; io_we = 0;
        reset = 0;
        @(negedge clk);
        check("rst_write_dropped", {48'd0, gpio_out}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
